// File: rtl/class_select_pkg.sv
// class_select shared defaults and sequencer state type.
// Holds parameter defaults for the argmax block and its sub-module.
package class_select_pkg;

  localparam int CS_DATA_WIDTH = 32;
  localparam int CS_N_CLASS    = 10;
  localparam int CS_IDX_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/top2_update.sv
// top2_update: one combinational step of a running top-2 search.
// In: max, second, idx, word, k. Out: max_n, second_n, idx_n.
module top2_update #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 4
) (
  input  logic [DATA_WIDTH-1:0] max,
  input  logic [DATA_WIDTH-1:0] second,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [IDX_W-1:0]      k,
  output logic [DATA_WIDTH-1:0] max_n,
  output logic [DATA_WIDTH-1:0] second_n,
  output logic [IDX_W-1:0]      idx_n
);

  logic gt_max;
  logic gt_sec;

  // Strict compare keeps the earlier (lower) index on a tie;
  // an equal word still lifts the runner-up.
  assign gt_max = word > max;
  assign gt_sec = !gt_max && (word > second);

  always_comb begin
    max_n    = max;
    second_n = second;
    idx_n    = idx;
    unique case (1'b1)
      gt_max: begin
        second_n = max;
        max_n    = word;
        idx_n    = k;
      end
      gt_sec: second_n = word;
      default: ;
    endcase
  end

endmodule

// File: rtl/class_select.sv
// class_select: captures ten class scores, scans one per cycle, reports
// winner index, value, margin to runner-up and all-zero flag (valid/ready).
module class_select
  import class_select_pkg::*;
#(
  parameter int DATA_WIDTH = CS_DATA_WIDTH,
  parameter int N_CLASS    = CS_N_CLASS,
  parameter int IDX_W      = CS_IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P0,
  input  logic [DATA_WIDTH-1:0] P1,
  input  logic [DATA_WIDTH-1:0] P2,
  input  logic [DATA_WIDTH-1:0] P3,
  input  logic [DATA_WIDTH-1:0] P4,
  input  logic [DATA_WIDTH-1:0] P5,
  input  logic [DATA_WIDTH-1:0] P6,
  input  logic [DATA_WIDTH-1:0] P7,
  input  logic [DATA_WIDTH-1:0] P8,
  input  logic [DATA_WIDTH-1:0] P9,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [IDX_W-1:0]      out_class,
  output logic [DATA_WIDTH-1:0] out_max,
  output logic [DATA_WIDTH-1:0] out_margin,
  output logic                  out_all_zero,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [DATA_WIDTH-1:0] pin  [10];
  logic [DATA_WIDTH-1:0] bank [N_CLASS];

  state_t                state;
  logic [IDX_W-1:0]      k_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] max_q;
  logic [DATA_WIDTH-1:0] sec_q;

  logic [IDX_W-1:0]      idx_n;
  logic [DATA_WIDTH-1:0] max_n;
  logic [DATA_WIDTH-1:0] sec_n;
  logic                  accept;
  logic                  last;

  assign pin = '{P0, P1, P2, P3, P4, P5, P6, P7, P8, P9};

  assign accept = in_valid && in_ready;
  assign last   = k_q == IDX_W'(N_CLASS - 1);

  // Snapshot of the inputs; the scan reads only this copy.
  for (genvar g = 0; g < N_CLASS; g++) begin : g_bank
    always_ff @(posedge clk) begin
      if (accept) bank[g] <= pin[g];
    end
  end

  top2_update #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_upd (
    .max     (max_q),
    .second  (sec_q),
    .idx     (idx_q),
    .word    (bank[k_q]),
    .k       (k_q),
    .max_n   (max_n),
    .second_n(sec_n),
    .idx_n   (idx_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_class    <= '0;
      out_max      <= '0;
      out_margin   <= '0;
      out_all_zero <= 1'b0;
      k_q          <= '0;
      idx_q        <= '0;
      max_q        <= '0;
      sec_q        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state    <= SCAN;
            in_ready <= 1'b0;
            max_q    <= pin[0];
            sec_q    <= '0;
            idx_q    <= '0;
            k_q      <= IDX_W'(1);
          end
        end
        SCAN: begin
          max_q <= max_n;
          sec_q <= sec_n;
          idx_q <= idx_n;
          k_q   <= k_q + 1'b1;
          if (last) begin
            // Publish straight from the final update so the
            // result lands on the same edge as the last compare.
            state        <= DONE;
            k_q          <= '0;
            out_valid    <= 1'b1;
            out_class    <= idx_n;
            out_max      <= max_n;
            out_margin   <= max_n - sec_n;
            out_all_zero <= max_n == '0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_class_select.sv
// tb_class_select: random + directed scoreboard bench for class_select.
// Expected results come from a sort-based model of the class vector.
module tb_class_select;

  typedef struct {
    logic [3:0]  cls;
    logic [31:0] mx;
    logic [31:0] mg;
    logic        z;
    longint      acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] p [10];
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  out_class;
  logic [31:0] out_max;
  logic [31:0] out_margin;
  logic        out_all_zero;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  bit     hold_ready = 1'b0;
  bit     rnd_ready  = 1'b0;
  exp_t   q [$];

  class_select dut (
    .clk         (clk),
    .rst         (rst),
    .P0          (p[0]),
    .P1          (p[1]),
    .P2          (p[2]),
    .P3          (p[3]),
    .P4          (p[4]),
    .P5          (p[5]),
    .P6          (p[6]),
    .P7          (p[7]),
    .P8          (p[8]),
    .P9          (p[9]),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_class   (out_class),
    .out_max     (out_max),
    .out_margin  (out_margin),
    .out_all_zero(out_all_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (hold_ready) out_ready = 1'b0;
    else if (rnd_ready) out_ready = $urandom_range(0, 3) != 0;
    else out_ready = 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Winner = largest value, lowest index among equals; runner-up is
  // the second entry of the descending-sorted multiset.
  function automatic exp_t model(input logic [31:0] v [10]);
    exp_t        e;
    logic [31:0] s [$];
    for (int i = 0; i < 10; i++) s.push_back(v[i]);
    s.rsort();
    e.mx  = s[0];
    e.mg  = s[0] - s[1];
    e.z   = s[0] == 0;
    e.cls = 0;
    for (int i = 9; i >= 0; i--) if (v[i] == s[0]) e.cls = 4'(i);
    e.acc = 0;
    return e;
  endfunction

  task automatic scramble();
    for (int i = 0; i < 10; i++) p[i] = $urandom;
  endtask

  task automatic gen(output logic [31:0] v [10]);
    int m;
    m = $urandom_range(0, 3);
    for (int i = 0; i < 10; i++) begin
      case (m)
        0: v[i] = $urandom;
        1: v[i] = $urandom_range(0, 3);
        2: v[i] = ($urandom_range(0, 9) == 0) ? $urandom : 32'd0;
        default: v[i] = $urandom_range(0, 1) ?
                        32'hFFFF_FFFF - $urandom_range(0, 2) :
                        32'($urandom_range(0, 5));
      endcase
    end
  endtask

  // Waits for in_ready (noise on in_valid/P while busy), then offers v.
  // Returns at the negedge after acceptance with in_valid low.
  task automatic send(input logic [31:0] v [10]);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      in_valid = $urandom_range(0, 1);
      scramble();
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stuck low");
      in_valid = 1'b0;
      return;
    end
    for (int i = 0; i < 10; i++) p[i] = v[i];
    in_valid = 1'b1;
    e = model(v);
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d", q.size());
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_out_max", out_max, 0);
    chk("rst_out_margin", out_margin, 0);
    chk("rst_out_all_zero", out_all_zero, 0);
  endtask

  // Monitor: pops on each new result, then checks hold and handshake.
  bit          seen = 1'b0;
  bit          hs_prev = 1'b0;
  exp_t        me;
  logic [3:0]  s_cls;
  logic [31:0] s_max;
  logic [31:0] s_mg;
  logic        s_z;

  always @(negedge clk) begin
    if (rst) begin
      seen    = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) begin
        chk("in_ready_after_hs", in_ready, 1);
        chk("valid_drop_after_hs", out_valid, 0);
      end
      if (out_valid) begin
        chk("in_ready_while_done", in_ready, 0);
        if (!seen) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: class=%0d max=%0h",
                     out_class, out_max);
          end else begin
            me = q.pop_front();
            chk("out_class", out_class, me.cls);
            chk("out_max", out_max, me.mx);
            chk("out_margin", out_margin, me.mg);
            chk("out_all_zero", out_all_zero, me.z);
            chk("latency", cyc - me.acc, 9);
          end
          s_cls = out_class;
          s_max = out_max;
          s_mg  = out_margin;
          s_z   = out_all_zero;
          seen  = 1'b1;
        end else begin
          chk("hold_class", out_class, s_cls);
          chk("hold_max", out_max, s_max);
          chk("hold_margin", out_margin, s_mg);
          chk("hold_all_zero", out_all_zero, s_z);
        end
      end
      hs_prev = out_valid && out_ready;
      if (hs_prev) seen = 1'b0;
    end
  end

  logic [31:0] v [10];
  int          n;

  initial begin
    for (int i = 0; i < 10; i++) p[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals();

    v = '{0, 0, 0, 5, 0, 0, 0, 0, 0, 0};
    send(v);
    v = '{1, 1, 1, 100, 1, 1, 1, 100, 1, 1};
    send(v);
    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send(v);
    drain();

    // Winner at the top index, full-scale values, stalled downstream.
    hold_ready = 1'b1;
    v = '{32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF};
    send(v);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reached_done", out_valid, 1);
    repeat (5) @(negedge clk);
    hold_ready = 1'b0;
    drain();

    // Abort mid-scan: reset during the fourth compare cycle.
    v = '{4, 8, 15, 16, 23, 42, 0, 1, 2, 3};
    send(v);
    repeat (3) @(negedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("aborted_no_valid", out_valid, 0);
    end
    v = '{7, 3, 9, 9, 1, 0, 2, 8, 9, 4};
    send(v);
    drain();

    rnd_ready = 1'b1;
    repeat (40) begin
      gen(v);
      send(v);
    end
    drain();
    rnd_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
